// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM state encoding and op decode for the mul/div unit.
// Macros are guarded so a common defines header can supply them first.
`ifndef EXE_MULT_OP
`define EXE_MULT_OP  8'b00011000
`define EXE_MULTU_OP 8'b00011001
`define EXE_DIV_OP   8'b00011010
`define EXE_DIVU_OP  8'b00011011
`endif

package mul_div_unit_pkg;

  localparam logic [7:0] OP_MULT  = `EXE_MULT_OP;
  localparam logic [7:0] OP_MULTU = `EXE_MULTU_OP;
  localparam logic [7:0] OP_DIV   = `EXE_DIV_OP;
  localparam logic [7:0] OP_DIVU  = `EXE_DIVU_OP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_valid(input logic [7:0] op);
    logic v;
    v = 1'b0;
    unique case (1'b1)
      op == OP_MULT:  v = 1'b1;
      op == OP_MULTU: v = 1'b1;
      op == OP_DIV:   v = 1'b1;
      op == OP_DIVU:  v = 1'b1;
      default:        v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate, used to take magnitudes and to
// restore result signs.
module sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? -x_i : x_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit: WIDTH run cycles plus a sign
// cycle and a done cycle; cancel aborts, reset clears everything.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic is_mul_q, is_mul_d;
  logic neg_hi_q, neg_hi_d;
  logic neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic done_q, done_d;

  logic signed_op, mul_op, sgn_x;
  logic [WIDTH-1:0] ua, ub;
  logic [2*WIDTH-1:0] prod_y;
  logic [WIDTH-1:0] quo_y, rem_y;
  logic [WIDTH:0] sum, shl;
  logic [WIDTH-1:0] sub;
  logic ge;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign mul_op    = (op == OP_MULT) || (op == OP_MULTU);
  assign sgn_x     = a[WIDTH-1] ^ b[WIDTH-1];

  sign_fix #(.WIDTH(WIDTH)) u_fix_a (
    .x_i(a), .neg_i(signed_op & a[WIDTH-1]), .y_o(ua)
  );
  sign_fix #(.WIDTH(WIDTH)) u_fix_b (
    .x_i(b), .neg_i(signed_op & b[WIDTH-1]), .y_o(ub)
  );
  sign_fix #(.WIDTH(2*WIDTH)) u_fix_p (
    .x_i({acc_hi_q, acc_lo_q}), .neg_i(neg_lo_q), .y_o(prod_y)
  );
  sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .x_i(acc_lo_q), .neg_i(neg_lo_q), .y_o(quo_y)
  );
  sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .x_i(acc_hi_q), .neg_i(neg_hi_q), .y_o(rem_y)
  );

  // Multiply: multiplier sits in acc_lo and shifts out as product shifts in.
  assign sum = {1'b0, acc_hi_q}
             + (acc_lo_q[0] ? {1'b0, dsr_q} : '0);
  // Divide: restoring step; a zero divisor always subtracts, giving all-ones.
  assign shl = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign ge  = shl >= {1'b0, dsr_q};
  assign sub = shl[WIDTH-1:0] - dsr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    dsr_d    = dsr_q;
    is_mul_d = is_mul_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !cancel && op_valid(op)) begin
          state_d  = RUN;
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = ua;
          dsr_d    = ub;
          is_mul_d = mul_op;
          neg_lo_d = signed_op & sgn_x & (mul_op | (|b));
          neg_hi_d = signed_op & (mul_op ? sgn_x : a[WIDTH-1]);
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (is_mul_q) begin
            acc_hi_d = sum[WIDTH:1];
            acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
          end else begin
            acc_hi_d = ge ? sub : shl[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ge};
          end
          if (cnt_q == LAST) state_d = SIGN;
        end
      end
      SIGN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (is_mul_q) begin
            {acc_hi_d, acc_lo_d} = prod_y;
          end else begin
            acc_hi_d = rem_y;
            acc_lo_d = quo_y;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          hi_d   = acc_hi_q;
          lo_d   = acc_lo_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      dsr_q    <= '0;
      is_mul_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      dsr_q    <= dsr_d;
      is_mul_q <= is_mul_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
